// File: rtl/lcd_print_sequencer_if.sv
// lcd_print_sequencer_if: byte handshake between the print sequencer and the LCD driver.
interface lcd_print_sequencer_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_is_cmd;
  logic       char_ready;
  modport master (output char_valid, char_data, char_is_cmd, input char_ready);
  modport slave  (input char_valid, char_data, char_is_cmd, output char_ready);
endinterface

// File: rtl/lcd_print_sequencer.sv
// lcd_print_sequencer: HD44780 init, then clears the panel and streams two lines
// of pattern characters to the LCD driver on each new display request.
module lcd_print_sequencer #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int CLEAR_CYCLES = 82000,
  parameter int COLS         = 16,
  localparam int IW          = $clog2(2 * COLS)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [2:0]            msg_sel,
  input  logic                  msg_req,
  output logic [2:0]            pat_msg,
  output logic [IW-1:0]         pat_idx,
  input  logic [7:0]            pat_char,
  lcd_print_sequencer_if.master lcd,
  output logic                  busy,
  output logic                  done
);
  localparam int CNT_MAX = (PWRUP_CYCLES > CLEAR_CYCLES ? PWRUP_CYCLES : CLEAR_CYCLES) - 1;
  localparam int CW      = CNT_MAX > 0 ? $clog2(CNT_MAX + 1) : 1;
  typedef enum logic [3:0] {PWRUP, INIT, IDLE, CLEAR, CLRWAIT, ADDR1, FETCH, SEND, ADDR2, FIN} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    init_q, init_d;
  logic          from_init_q, from_init_d;
  logic [2:0]    msg_q, msg_d, shown_q, shown_d, pend_sel_q, pend_sel_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    char_q, char_d;
  logic          busy_q;
  logic          xfer, cnt_pw, cnt_clr, go;
  logic [2:0]    eff_sel;
  logic [7:0]    init_cmd;
  assign xfer     = lcd.char_valid & lcd.char_ready;
  assign cnt_pw   = cnt_q == CW'(PWRUP_CYCLES - 1);
  assign cnt_clr  = cnt_q == CW'(CLEAR_CYCLES - 1);
  // a request arriving in the decision cycle itself outranks the stored one
  assign eff_sel  = msg_req ? msg_sel : pend_sel_q;
  assign go       = (msg_req | pend_q) & (eff_sel != (state_q == FIN ? msg_q : shown_q));
  assign init_cmd = init_q == 2'd0 ? 8'h38 : init_q == 2'd1 ? 8'h0C : init_q == 2'd2 ? 8'h06 : 8'h01;
  assign lcd.char_valid  = state_q inside {INIT, CLEAR, ADDR1, SEND, ADDR2};
  assign lcd.char_is_cmd = state_q inside {INIT, CLEAR, ADDR1, ADDR2};
  assign lcd.char_data   = state_q == INIT  ? init_cmd :
                           state_q == CLEAR ? 8'h01 :
                           state_q == ADDR1 ? 8'h80 :
                           state_q == ADDR2 ? 8'hC0 :
                           state_q == SEND  ? char_q : 8'h00;
  assign pat_msg = msg_q;
  assign pat_idx = idx_q;
  assign busy    = busy_q;
  assign done    = state_q == FIN;
  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    from_init_d = from_init_q;
    msg_d       = msg_q;
    shown_d     = shown_q;
    idx_d       = idx_q;
    char_d      = char_q;
    pend_d      = pend_q | (msg_req & state_q != IDLE);
    pend_sel_d  = (msg_req & state_q != IDLE) ? msg_sel : pend_sel_q;
    unique case (state_q)
      PWRUP: if (cnt_pw) begin
        state_d = INIT;
        init_d  = 2'd0;
      end
      INIT: if (xfer) begin
        init_d = init_q + 2'd1;
        if (init_q == 2'd3) begin
          state_d     = CLRWAIT;
          from_init_d = 1'b1;
        end
      end
      IDLE: if (go) begin
        msg_d   = eff_sel;
        state_d = CLEAR;
      end
      CLEAR: if (xfer) begin
        state_d     = CLRWAIT;
        from_init_d = 1'b0;
      end
      CLRWAIT: if (cnt_clr) begin
        state_d = from_init_q ? (go ? CLEAR : IDLE) : ADDR1;
        pend_d  = from_init_q ? 1'b0 : pend_d;
        msg_d   = (from_init_q & go) ? eff_sel : msg_q;
      end
      ADDR1: if (xfer) begin
        idx_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        char_d  = pat_char;
        state_d = SEND;
      end
      SEND: if (xfer) begin
        state_d = idx_q == IW'(COLS - 1) ? ADDR2 : idx_q == IW'(2 * COLS - 1) ? FIN : FETCH;
        idx_d   = (idx_q == IW'(COLS - 1) || idx_q == IW'(2 * COLS - 1)) ? idx_q : idx_q + IW'(1);
      end
      ADDR2: if (xfer) begin
        idx_d   = IW'(COLS);
        state_d = FETCH;
      end
      FIN: begin
        shown_d = msg_q;
        pend_d  = 1'b0;
        state_d = go ? CLEAR : IDLE;
        msg_d   = go ? eff_sel : msg_q;
      end
      default: state_d = PWRUP;
    endcase
  end
  assign cnt_d = state_d != state_q ? '0 : cnt_q == CW'(CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= PWRUP;
      cnt_q       <= '0;
      init_q      <= '0;
      from_init_q <= 1'b0;
      msg_q       <= '0;
      shown_q     <= 3'd7;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      idx_q       <= '0;
      char_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      from_init_q <= from_init_d;
      msg_q       <= msg_d;
      shown_q     <= shown_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      idx_q       <= idx_d;
      char_q      <= char_d;
      busy_q      <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_lcd_print_sequencer.sv
// tb_lcd_print_sequencer: directed scenarios with a byte scoreboard on the driver handshake.
module tb_lcd_print_sequencer;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [2:0] msg_sel = '0;
  logic       msg_req = 1'b0;
  logic [2:0] pat_msg;
  logic [4:0] pat_idx;
  logic [7:0] pat_char;
  logic       busy, done;
  logic       bp = 1'b0, rnd = 1'b1;
  int         checks = 0, failures = 0, done_cnt = 0, edge_cnt = 0, last_xfer_edge = 0;
  logic [8:0] sb[$];
  logic       stall_q = 1'b0;
  logic [8:0] stall_byte = '0;

  lcd_print_sequencer_if lcd_bus();

  lcd_print_sequencer #(.PWRUP_CYCLES(10), .CLEAR_CYCLES(5), .COLS(16)) dut (
    .clk(clk), .rstb(rstb), .msg_sel(msg_sel), .msg_req(msg_req),
    .pat_msg(pat_msg), .pat_idx(pat_idx), .pat_char(pat_char),
    .lcd(lcd_bus.master), .busy(busy), .done(done));

  always #5 clk = ~clk;
  // pattern source: message m, index i yields 0x3E+m+i (message 3 gives 'A'+i)
  assign pat_char = 8'h3E + 8'(pat_msg) + 8'(pat_idx);
  assign lcd_bus.char_ready = bp ? rnd : 1'b1;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    #1 rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstb) begin
      if (stall_q) begin
        chk("hold_valid", 32'(lcd_bus.char_valid), 32'd1);
        chk("hold_data", 32'({lcd_bus.char_is_cmd, lcd_bus.char_data}), 32'(stall_byte));
      end
      stall_q    = lcd_bus.char_valid & ~lcd_bus.char_ready;
      stall_byte = {lcd_bus.char_is_cmd, lcd_bus.char_data};
      if (done) done_cnt++;
      if (lcd_bus.char_valid && lcd_bus.char_ready) begin
        last_xfer_edge = edge_cnt + 1;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("byte", 32'({lcd_bus.char_is_cmd, lcd_bus.char_data}), 32'(sb.pop_front()));
      end
    end else stall_q = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    sb.push_back({1'b1, 8'h38});
    sb.push_back({1'b1, 8'h0C});
    sb.push_back({1'b1, 8'h06});
    sb.push_back({1'b1, 8'h01});
  endtask

  task automatic push_msg(input logic [2:0] m);
    sb.push_back({1'b1, 8'h01});
    sb.push_back({1'b1, 8'h80});
    for (int i = 0; i < 16; i++) sb.push_back({1'b0, 8'h3E + 8'(m) + 8'(i)});
    sb.push_back({1'b1, 8'hC0});
    for (int i = 16; i < 32; i++) sb.push_back({1'b0, 8'h3E + 8'(m) + 8'(i)});
  endtask

  task automatic req(input logic [2:0] m);
    msg_sel = m;
    msg_req = 1'b1;
    tick();
    msg_req = 1'b0;
  endtask

  // releases reset and checks the 10-cycle silence before the first command
  task automatic pwrup(input bit with_req, input logic [2:0] m);
    rstb = 1'b1;
    chk("pwrup_quiet", 32'(lcd_bus.char_valid), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      msg_sel = m;
      msg_req = with_req && k == 3;
      tick();
      chk(k < 10 ? "pwrup_quiet" : "init_start", 32'(lcd_bus.char_valid), k < 10 ? 32'd0 : 32'd1);
    end
    msg_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idx(input logic [4:0] v);
    int n = 0;
    while (!(pat_idx == v && lcd_bus.char_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("wait_idx_timeout", 32'(pat_idx == v && lcd_bus.char_valid), 32'd1);
  endtask

  initial begin
    int d0;
    logic quiet;
    #2;
    chk("rst_valid", 32'(lcd_bus.char_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pat", 32'({pat_msg, pat_idx}), 32'd0);
    chk("rst_data", 32'({lcd_bus.char_is_cmd, lcd_bus.char_data}), 32'd0);
    tick();
    push_init();
    pwrup(1'b0, 3'd0);
    wait_idle("init");
    chk("init_clrwait", 32'(edge_cnt - last_xfer_edge), 32'd5);
    chk("init_sb_empty", 32'(sb.size()), 32'd0);
    chk("init_no_done", 32'(done_cnt), 32'd0);
    d0 = done_cnt;
    push_msg(3'd3);
    req(3'd3);
    chk("msg3_busy", 32'(busy), 32'd1);
    wait_idle("msg3");
    chk("msg3_sb_empty", 32'(sb.size()), 32'd0);
    chk("msg3_done", 32'(done_cnt - d0), 32'd1);
    chk("msg3_pat_msg", 32'(pat_msg), 32'd3);
    d0 = done_cnt;
    bp = 1'b1;
    push_msg(3'd2);
    req(3'd2);
    wait_idle("msg2_bp");
    bp = 1'b0;
    chk("msg2_sb_empty", 32'(sb.size()), 32'd0);
    chk("msg2_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    push_msg(3'd1);
    req(3'd1);
    wait_idx(5'd3);
    req(3'd4);
    tick();
    tick();
    push_msg(3'd5);
    req(3'd5);
    wait_idle("pend");
    chk("pend_sb_empty", 32'(sb.size()), 32'd0);
    chk("pend_done", 32'(done_cnt - d0), 32'd2);
    chk("pend_pat_msg", 32'(pat_msg), 32'd5);
    d0 = done_cnt;
    quiet = 1'b1;
    req(3'd5);
    for (int k = 0; k < 20; k++) begin
      quiet &= ~busy & ~lcd_bus.char_valid;
      tick();
    end
    chk("dup_quiet", 32'(quiet), 32'd1);
    chk("dup_no_done", 32'(done_cnt - d0), 32'd0);
    push_msg(3'd3);
    req(3'd3);
    wait_idx(5'd7);
    rstb = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(lcd_bus.char_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pat", 32'({pat_msg, pat_idx}), 32'd0);
    chk("mid_rst_data", 32'({lcd_bus.char_is_cmd, lcd_bus.char_data}), 32'd0);
    chk("mid_rst_left", 32'(sb.size()), 32'd26);
    sb.delete();
    tick();
    tick();
    d0 = done_cnt;
    push_init();
    push_msg(3'd5);
    pwrup(1'b1, 3'd5);
    wait_idle("rerun");
    chk("rerun_sb_empty", 32'(sb.size()), 32'd0);
    chk("rerun_done", 32'(done_cnt - d0), 32'd1);
    chk("rerun_pat_msg", 32'(pat_msg), 32'd5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
